// File: rtl/fp32_mul_pipe.sv
// fp32_mul_pipe: pipelined IEEE-754 single-precision multiplier.
// An operand capture rank feeds three datapath stages (unpack, significand product,
// normalise/round/pack). A pair sampled on edge N appears on c/overflow/out_valid
// after edge N+3. Subnormal inputs are treated as zero and tiny results flush to zero.
// Build option: define FPMUL_RNE_EN for round-to-nearest-even; the default build
// truncates (round toward zero) and carries no rounding adder.

module fp32_mul_pipe #(
  parameter int unsigned LATENCY = 3  // only 3 is supported
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] c,
  output logic        overflow,
  output logic        out_valid
);

  // Result class, resolved by priority in stage 1 and carried to the pack stage.
  typedef enum logic [1:0] {ClsNorm, ClsZero, ClsInf, ClsNan} cls_e;

  // Truncation only needs product bits [47:23], so the stage-2 register is narrower.
`ifdef FPMUL_RNE_EN
  localparam int unsigned ProdW = 48;
`else
  localparam int unsigned ProdW = 25;
`endif
  localparam int unsigned ProdLsb = 48 - ProdW;

  // Valid chain: [0] operand capture, [1] stage 1, [2] stage 2, [LATENCY] output.
  logic [LATENCY:0] vld_q;
  logic [31:0]      op_a_q, op_b_q;

  // Stage 1 signals
  logic [7:0]  ea, eb;
  logic        a_zero, a_inf, a_nan;
  logic        b_zero, b_inf, b_nan;
  logic        s1_sign_d, s1_sign_q;
  logic [9:0]  s1_exp_d, s1_exp_q;
  logic [23:0] s1_ma_d, s1_ma_q;
  logic [23:0] s1_mb_d, s1_mb_q;
  cls_e        s1_cls_d, s1_cls_q;

  // Stage 2 signals
  logic             s2_sign_q;
  logic [9:0]       s2_exp_q;
  logic [ProdW-1:0] s2_prod_d, s2_prod_q;
  cls_e             s2_cls_q;

  // Stage 3 signals
  logic               norm;
  logic [22:0]        frac;
  logic [23:0]        frac_r;  // [23] is the rounding carry-out
  logic signed [10:0] exp_n;
  logic [31:0]        c_d;
  logic               ov_d;
`ifdef FPMUL_RNE_EN
  logic               guard, rnd, sticky, round_up;
`endif

  // Output registers
  logic [31:0] c_q;
  logic        overflow_q;

  // Operand capture and valid chain; reset drops every in-flight pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
    end else begin
      vld_q  <= {vld_q[LATENCY-1:0], in_valid};
      op_a_q <= a;
      op_b_q <= b;
    end
  end

  // Stage 1 decode: unpack, classify operands, biased exponent sum.
  always_comb begin
    ea     = op_a_q[30:23];
    eb     = op_b_q[30:23];
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    a_inf  = (ea == 8'hFF) && (op_a_q[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (op_b_q[22:0] == 23'd0);
    a_nan  = (ea == 8'hFF) && (op_a_q[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (op_b_q[22:0] != 23'd0);

    s1_sign_d = op_a_q[31] ^ op_b_q[31];
    s1_exp_d  = {2'b00, ea} + {2'b00, eb} - 10'd127;
    s1_ma_d   = {1'b1, op_a_q[22:0]};
    s1_mb_d   = {1'b1, op_b_q[22:0]};

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      s1_cls_d = ClsNan;
    end else if (a_inf || b_inf) begin
      s1_cls_d = ClsInf;
    end else if (a_zero || b_zero) begin
      s1_cls_d = ClsZero;
    end else begin
      s1_cls_d = ClsNorm;
    end
  end

  // Stage 2 product: full 48-bit product, keeping only the bits the pack stage needs.
  always_comb begin
    s2_prod_d = ProdW'(({24'd0, s1_ma_q} * {24'd0, s1_mb_q}) >> ProdLsb);
  end

  // Stage 1 and stage 2 pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_sign_q <= 1'b0;
      s1_exp_q  <= '0;
      s1_ma_q   <= '0;
      s1_mb_q   <= '0;
      s1_cls_q  <= ClsNorm;
      s2_sign_q <= 1'b0;
      s2_exp_q  <= '0;
      s2_prod_q <= '0;
      s2_cls_q  <= ClsNorm;
    end else begin
      s1_sign_q <= s1_sign_d;
      s1_exp_q  <= s1_exp_d;
      s1_ma_q   <= s1_ma_d;
      s1_mb_q   <= s1_mb_d;
      s1_cls_q  <= s1_cls_d;
      s2_sign_q <= s1_sign_q;
      s2_exp_q  <= s1_exp_q;
      s2_prod_q <= s2_prod_d;
      s2_cls_q  <= s1_cls_q;
    end
  end

  // Stage 3: normalise, round, then apply special-case priority and pack.
  always_comb begin
    norm = s2_prod_q[ProdW-1];  // product bit 47: significand in [2,4)
`ifdef FPMUL_RNE_EN
    if (norm) begin
      frac   = s2_prod_q[46:24];
      guard  = s2_prod_q[23];
      rnd    = s2_prod_q[22];
      sticky = |s2_prod_q[21:0];
    end else begin
      frac   = s2_prod_q[45:23];
      guard  = s2_prod_q[22];
      rnd    = s2_prod_q[21];
      sticky = |s2_prod_q[20:0];
    end
    round_up = guard & (rnd | sticky | frac[0]);
    // All-ones fraction rounding up wraps to zero with a carry: value becomes 2.0.
    frac_r   = {1'b0, frac} + {23'd0, round_up};
`else
    frac   = norm ? s2_prod_q[23:1] : s2_prod_q[22:0];
    frac_r = {1'b0, frac};
`endif
    exp_n = $signed({s2_exp_q[9], s2_exp_q}) + $signed({10'd0, norm})
          + $signed({10'd0, frac_r[23]});

    c_d  = {s2_sign_q, exp_n[7:0], frac_r[22:0]};
    ov_d = 1'b0;
    case (s2_cls_q)
      ClsNan:  c_d = 32'h7FC0_0000;
      ClsInf:  c_d = {s2_sign_q, 8'hFF, 23'd0};
      ClsZero: c_d = {s2_sign_q, 31'd0};
      default: begin
        if (exp_n >= 11'sd255) begin
          c_d  = {s2_sign_q, 8'hFF, 23'd0};
          ov_d = 1'b1;
        end else if (exp_n <= 11'sd0) begin
          c_d = {s2_sign_q, 31'd0};
        end
      end
    endcase
  end

  // Output register: c holds across bubbles, overflow only ever high with out_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q        <= '0;
      overflow_q <= 1'b0;
    end else if (vld_q[LATENCY-1]) begin
      c_q        <= c_d;
      overflow_q <= ov_d;
    end else begin
      overflow_q <= 1'b0;
    end
  end

  assign c         = c_q;
  assign overflow  = overflow_q;
  assign out_valid = vld_q[LATENCY];

endmodule

// File: tb/tb_fp32_mul_pipe.sv
// Bench for fp32_mul_pipe: directed test-plan vectors plus randomized traffic checked
// against an integer-arithmetic reference model and a latency-aligned expectation queue.

module tb_fp32_mul_pipe;

  localparam int unsigned Lat = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] a, b, c;
  logic        overflow, out_valid;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct packed {
    logic        v;
    logic [31:0] c;
    logic        ov;
  } exp_t;

  exp_t        hist[$];
  logic [31:0] last_c;
  string       phase;

  always #5 clk = ~clk;

  fp32_mul_pipe #(.LATENCY(Lat)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .c        (c),
    .overflow (overflow),
    .out_valid(out_valid)
  );

  // Reference: returns {overflow, c}, computed from the value-level rules.
  function automatic logic [32:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int              ex, ey, e, sh;
    logic            s;
    bit              xz, yz, xi, yi, xn, yn;
    longint unsigned p, keep;
`ifdef FPMUL_RNE_EN
    longint unsigned rem, half;
`endif
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    if (xn || yn || (xi && yz) || (yi && xz)) return {1'b0, 32'h7FC0_0000};
    if (xi || yi) return {1'b0, s, 8'hFF, 23'd0};
    if (xz || yz) return {1'b0, s, 31'd0};
    p  = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
    e  = ex + ey - 127;
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    e  = e + sh - 23;
    keep = p >> sh;
`ifdef FPMUL_RNE_EN
    rem  = p & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep = keep + 1;
    if (keep == (64'd1 << 24)) begin
      keep = keep >> 1;
      e    = e + 1;
    end
`endif
    if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
    if (e <= 0) return {1'b0, s, 31'd0};
    return {1'b0, s, e[7:0], keep[22:0]};
  endfunction

  // Operand generator biased toward classes and exponent edges.
  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0:       r[30:23] = 8'd0;
      1:       r[30:23] = 8'hFF;
      2:       begin r[30:23] = 8'hFF; r[22:0] = '0; end
      3:       r[30:23] = 8'd254;
      4:       r[30:23] = 8'd1;
      5:       r[22:0]  = 23'h7FFFFF;
      default: r[30:23] = 8'($urandom_range(64, 190));
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_miss++;
      $error("FAIL %s.%s: observed %h expected %h", phase, tag, got, want);
    end
  endtask

  // One clock: drive at negedge, compare output of the pair issued Lat edges earlier.
  task automatic tick_core(input logic v, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] cw, input logic ovw);
    exp_t ent, e;
    in_valid = v;
    a        = x;
    b        = y;
    ent.v    = v;
    ent.c    = cw;
    ent.ov   = ovw;
    @(posedge clk);
    hist.push_back(ent);
    #1;
    if (hist.size() > Lat) begin
      e = hist.pop_front();
      if (e.v) last_c = e.c;
      check("out_valid", 32'(out_valid), 32'(e.v));
      check("c", c, last_c);
      check("overflow", 32'(overflow), e.v ? 32'(e.ov) : 32'd0);
    end
    @(negedge clk);
  endtask

  task automatic tick(input logic v, input logic [31:0] x, input logic [31:0] y);
    logic [32:0] r;
    r = ref_mul(x, y);
    tick_core(v, x, y, r[31:0], r[32]);
  endtask

  task automatic tick_k(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] cw, input logic ovw);
    tick_core(1'b1, x, y, cw, ovw);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'd0, 32'd0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    exp_t z;
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_c", c, 32'd0);
    check("rst_ov", 32'(overflow), 32'd0);
    check("rst_vld", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("rst_vld_hold", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    last_c = 32'd0;
    hist.delete();
    z = '0;
    for (int i = 0; i < Lat; i++) hist.push_back(z);
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    last_c   = '0;
    #2;
    phase = "reset";
    do_reset();

    phase = "basic";
    tick_k(32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 1'b0);
    idle(4);

    phase = "special";
    tick_k(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1);
    idle(1);
    tick_k(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0);
    tick_k(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 1'b0);
    tick_k(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0);
    tick_k(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0);
    tick_k(32'h7FC0_1234, 32'h3F80_0000, 32'h7FC0_0000, 1'b0);
`ifdef FPMUL_RNE_EN
    tick_k(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 1'b0);
    tick_k(32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 1'b0);
`else
    tick_k(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0001, 1'b0);
    tick_k(32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 1'b0);
`endif
    idle(4);

    phase = "stream";
    for (int i = 0; i < 32; i++) begin
      if (i == 7) tick_k(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0);
      else tick(1'b1, rnd_op(), rnd_op());
    end
    idle(4);

    phase = "random";
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 3) != 0), rnd_op(), rnd_op());
    end
    idle(4);

    phase = "midreset";
    tick_k(32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 1'b0);
    tick_k(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1);
    tick_k(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0);
    do_reset();
    idle(6);

    phase = "after";
    for (int i = 0; i < 8; i++) tick(1'b1, rnd_op(), rnd_op());
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fp32_mul_pipe.md
Name: fp32_mul_pipe

Overview:
- 3-stage pipelined IEEE-754 single-precision multiplier; the datapath stage between the operand/result memory stack and itself.
- Consumes operands a/b that the memory stack reads out one cycle after its start strobe.
- Produces product c plus overflow flag; out_valid drives the memory's we and we_ov directly.
- No backpressure: one operand pair accepted per cycle, results emerge in order.

Parameters:
- LATENCY, 3, pipeline depth in cycles; only value 3 is supported. Exposed for benches and the controller.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  a/b hold a valid operand pair this cycle
- a  input  32  multiplier, IEEE-754 single
- b  input  32  multiplicand, IEEE-754 single
- c  output  32  product, IEEE-754 single
- overflow  output  1  product exponent exceeded max finite; qualified by out_valid
- out_valid  output  1  c/overflow valid; connect to memory we and we_ov

Behaviour:
- Reset:
  - one clock (clk); reset is asynchronous, active-high.
  - c=0, overflow=0, out_valid=0; all stage valid bits and stage registers cleared immediately.
  - Reset asserted mid-operation discards every in-flight result; no partial write occurs afterwards.
- Timing:
  - pair sampled at edge N when in_valid=1; c/overflow/out_valid registered and valid after edge N+3.
  - Throughput 1/cycle; bubbles (in_valid=0) propagate as out_valid=0.
  - c/overflow hold their last values when out_valid=0.
- Stage 1:
  - unpack; sign = a[31]^b[31]; exp_sum = ea+eb-127 in 10-bit signed.
  - Classify each operand as zero (e=0, subnormals treated as zero), inf, or nan.
- Stage 2: 24x24 significand product (hidden 1 restored), 48-bit result; classification and sign carried along.
- Stage 3:
  - if product[47]=1, shift right 1 and exp+1.
  - Round (see Optional Feature); a rounding carry-out renormalises and exp+1.
  - Pack.
- Result rules, in priority order:
  - any NaN, or inf*zero -> c=0x7FC00000, overflow=0.
  - inf*finite/inf -> sign|0x7F800000, overflow=0.
  - zero*finite -> sign|0x00000000, overflow=0.
  - final exp>=255 -> sign|0x7F800000, overflow=1.
  - final exp<=0 -> flush to sign|0x00000000, overflow=0 (no underflow flag).
  - otherwise normal pack, overflow=0.
- Overflow is asserted only on cycles with out_valid=1.

Optional Feature:
- Macro FPMUL_RNE_EN.
- Defined: round-to-nearest-even using guard/round/sticky from the discarded product bits.
- Undefined: truncation (round toward zero); discarded bits ignored; no rounding adder in stage 3.
- Latency is 3 in both builds.

Test Plan:
- a=0x40400000, b=0x40000000, in_valid one cycle -> out_valid exactly 3 cycles later, c=0x40C00000, overflow=0.
- Back-to-back stream, 32 pairs, in_valid held high, including 0x3FC00000*0x3FC00000 -> 32 consecutive out_valid cycles in order; that pair gives c=0x40100000.
- a=0x7F000000, b=0x7F000000 -> c=0x7F800000, overflow=1. a=0x7F800000, b=0x00000000 -> c=0x7FC00000, overflow=0.
- a=0x80000000, b=0x3F800000 -> c=0x80000000. a=0x00800000, b=0x00800000 -> c=0x00000000, overflow=0.
- a=0x3F800001, b=0x3FC00000 -> c=0x3FC00002 with FPMUL_RNE_EN; c=0x3FC00001 without it.
- Issue 3 pairs, pulse reset at cycle 2 of flight -> out_valid never asserts for those pairs; c=0, overflow=0 immediately on reset.
